// File: rtl/axis_rr_arbiter_pkg.sv
// axis_rr_arbiter_pkg: shared stream width, FSM state encoding and sizing helper
package axis_rr_arbiter_pkg;
  localparam int AXIS_DATA_W = 8;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axis_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first set req bit at or above ptr with wrap
// Ports: req (request vector), ptr (search start index), gnt (one-hot winner), any (some request set)
module rr_pick
  import axis_rr_arbiter_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int PW    = idx_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_SRC-1:0] gnt,
  output logic             any
);
  logic [N_SRC-1:0] rot;
  logic [N_SRC-1:0] first;
  always_comb begin
    rot = '0;
    gnt = '0;
    for (int i = 0; i < N_SRC; i++) rot[i] = req[(i + int'(ptr)) % N_SRC];
    first = rot & (~rot + N_SRC'(1));
    for (int i = 0; i < N_SRC; i++) gnt[(i + int'(ptr)) % N_SRC] = first[i];
  end
  assign any = |req;
endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin arbiter sharing one AXI-stream sink among N_SRC masters
// Ports: clk, reset_n (async, active-low); s_data/s_valid/s_last/s_ready per-source stream;
//        m_data/m_valid/m_last/m_ready sink stream; grant (one-hot owner, 0 when idle);
//        pkt_done (pulse after final handshake); timeout_err (pulse when MAX_BEATS forced the release)
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = AXIS_DATA_W,
  parameter int MAX_BEATS = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_SRC*DATA_W-1:0] s_data,
  input  logic [N_SRC-1:0]        s_valid,
  input  logic [N_SRC-1:0]        s_last,
  output logic [N_SRC-1:0]        s_ready,
  output logic [DATA_W-1:0]       m_data,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic [N_SRC-1:0]        grant,
  output logic                    pkt_done,
  output logic                    timeout_err
);
  localparam int PW = idx_w(N_SRC);
  localparam int CW = $clog2(MAX_BEATS) + 1;
  state_t           state, state_nx;
  logic [N_SRC-1:0] grant_nx, pick;
  logic             pick_any;
  logic [PW-1:0]    rr_ptr, ptr_nx, owner;
  logic [CW-1:0]    beat_cnt, cnt_nx;
  logic             src_last, hs, done;
  rr_pick #(.N_SRC(N_SRC), .PW(PW)) u_pick (
    .req(s_valid),
    .ptr(rr_ptr),
    .gnt(pick),
    .any(pick_any)
  );
  // grant is all-zero while idle, so every sink-side output naturally reads 0 then
  always_comb begin
    m_data = '0;
    owner  = '0;
    for (int i = 0; i < N_SRC; i++)
      if (grant[i]) begin
        m_data = s_data[i*DATA_W +: DATA_W];
        owner  = PW'(i);
      end
    m_valid  = |(s_valid & grant);
    src_last = |(s_last & grant);
    m_last   = (|grant) && (src_last || beat_cnt == CW'(MAX_BEATS - 1));
    s_ready  = grant & {N_SRC{m_ready}};
    hs       = m_valid && m_ready;
    done     = hs && m_last;
  end
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    ptr_nx   = rr_ptr;
    cnt_nx   = beat_cnt;
    if (state == ST_IDLE) begin
      state_nx = pick_any ? ST_GRANT : ST_IDLE;
      grant_nx = pick_any ? pick : '0;
    end else if (done) begin
      state_nx = ST_IDLE;
      grant_nx = '0;
      cnt_nx   = '0;
      ptr_nx   = (owner == PW'(N_SRC - 1)) ? '0 : owner + PW'(1);
    end else if (hs) begin
      cnt_nx = beat_cnt + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      pkt_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      rr_ptr      <= ptr_nx;
      beat_cnt    <= cnt_nx;
      pkt_done    <= done;
      timeout_err <= done && !src_last;
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: scoreboard bench for axis_rr_arbiter with queued sources and a sink monitor
module tb_axis_rr_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] s_data;
  logic [3:0]  s_valid, s_last, s_ready, grant;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_ready, pkt_done, timeout_err;
  logic [8:0]  sq [4][$];
  logic [12:0] exp_q[$];
  logic        to_q[$];
  logic [3:0]  pop = '0;
  logic        prev_stall = 1'b0, prev_last = 1'b0;
  logic [12:0] prev_beat = '0;
  int          n_checks = 0, n_err = 0;
  axis_rr_arbiter #(.N_SRC(4), .DATA_W(8), .MAX_BEATS(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .grant(grant), .pkt_done(pkt_done), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < 4; i++)
      if (sq[i].size() != 0) begin
        s_valid[i]       = 1'b1;
        s_last[i]        = sq[i][0][0];
        s_data[i*8 +: 8] = sq[i][0][8:1];
      end else begin
        s_valid[i]       = 1'b0;
        s_last[i]        = 1'b0;
        s_data[i*8 +: 8] = 8'h00;
      end
  endtask
  task automatic src(input int s, input logic [7:0] d, input logic l);
    sq[s].push_back({d, l});
  endtask
  task automatic expb(input logic [3:0] g, input logic [7:0] d, input logic l);
    exp_q.push_back({g, d, l});
  endtask
  function automatic int pending();
    return sq[0].size() + sq[1].size() + sq[2].size() + sq[3].size() + exp_q.size() + to_q.size();
  endfunction
  task automatic drain(input string name, input logic toggle);
    int k = 0;
    while (pending() != 0 && k < 300) begin
      @(posedge clk); #1;
      if (toggle) m_ready = ~m_ready;
      k++;
    end
    m_ready = 1'b1;
    chk(name, 32'(k < 300), 32'd1);
    @(posedge clk); #1;
  endtask
  // sources present their queue head; a head is consumed only after a handshake seen before the edge
  always @(negedge clk) pop = s_valid & s_ready;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++)
      if (pop[i] && sq[i].size() != 0) void'(sq[i].pop_front());
    drive();
  end
  always @(negedge clk)
    if (!reset_n) begin
      prev_stall = 1'b0;
      prev_last  = 1'b0;
    end else begin
      if (prev_last) chk("idle_gap", 32'(m_valid), 32'd0);
      if (prev_stall) chk("stall_hold", 32'({grant, m_data, m_last}), 32'(prev_beat));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL extra_beat: got %0h expected none", {grant, m_data, m_last});
        end else chk("beat", 32'({grant, m_data, m_last}), 32'(exp_q.pop_front()));
      end
      if (pkt_done) begin
        if (to_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL extra_pkt_done: got 1 expected 0");
        end else chk("timeout_err", 32'(timeout_err), 32'(to_q.pop_front()));
      end else if (timeout_err) begin
        n_checks++;
        n_err++;
        $display("FAIL stray_timeout: got 1 expected 0");
      end
      prev_stall = m_valid && !m_ready;
      prev_beat  = {grant, m_data, m_last};
      prev_last  = m_valid && m_ready && m_last;
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    reset_n = 1'b0;
    m_ready = 1'b1;
    s_data  = '0;
    s_valid = '0;
    s_last  = '0;
    src(0, 8'hAA, 0); src(0, 8'hAB, 0); src(0, 8'hAC, 1);
    src(2, 8'hC0, 0); src(2, 8'hC1, 0); src(2, 8'hC2, 1);
    drive();
    expb(4'b0001, 8'hAA, 0); expb(4'b0001, 8'hAB, 0); expb(4'b0001, 8'hAC, 1);
    expb(4'b0100, 8'hC0, 0); expb(4'b0100, 8'hC1, 0); expb(4'b0100, 8'hC2, 1);
    to_q.push_back(0); to_q.push_back(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_pulses", 32'({pkt_done, timeout_err}), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("first_grant", 32'(grant), 32'b0001);
    drain("drain_two_pkts", 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst2_grant", 32'(grant), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    src(0, 8'h30, 1); src(1, 8'h31, 1); src(2, 8'h32, 1); src(3, 8'h33, 1); src(0, 8'h34, 1);
    drive();
    expb(4'b0001, 8'h30, 1); expb(4'b0010, 8'h31, 1); expb(4'b0100, 8'h32, 1);
    expb(4'b1000, 8'h33, 1); expb(4'b0001, 8'h34, 1);
    repeat (5) to_q.push_back(0);
    drain("drain_rotation", 1'b0);
    src(1, 8'h40, 0); src(1, 8'h41, 0); src(1, 8'h42, 0); src(1, 8'h43, 1);
    drive();
    expb(4'b0010, 8'h40, 0); expb(4'b0010, 8'h41, 0); expb(4'b0010, 8'h42, 0); expb(4'b0010, 8'h43, 1);
    to_q.push_back(0);
    drain("drain_stall", 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    src(1, 8'h50, 0); src(1, 8'h51, 0); src(1, 8'h52, 0); src(1, 8'h53, 0);
    src(1, 8'h54, 0); src(1, 8'h55, 1); src(2, 8'h60, 1);
    drive();
    expb(4'b0010, 8'h50, 0); expb(4'b0010, 8'h51, 0); expb(4'b0010, 8'h52, 0); expb(4'b0010, 8'h53, 1);
    expb(4'b0100, 8'h60, 1);
    expb(4'b0010, 8'h54, 0); expb(4'b0010, 8'h55, 1);
    to_q.push_back(1); to_q.push_back(0); to_q.push_back(0);
    drain("drain_timeout", 1'b0);
    src(3, 8'h70, 0); src(3, 8'h71, 0); src(3, 8'h72, 1);
    drive();
    expb(4'b1000, 8'h70, 0); expb(4'b1000, 8'h71, 0); expb(4'b1000, 8'h72, 1);
    to_q.push_back(0);
    begin
      int k = 0;
      while (!(m_valid && m_data == 8'h71) && k < 50) begin
        @(posedge clk); #2;
        k++;
      end
      chk("reach_beat2", 32'(k < 50), 32'd1);
    end
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_s_ready", 32'(s_ready), 32'd0);
    chk("async_m_valid", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rearb_grant", 32'(grant), 32'b1000);
    drain("drain_rearb", 1'b0);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
